mem_channel_arbiter: RTL
========================

// Module: mem_channel_arbiter
// PURPOSE
//  Parametrised shared-memory port for the accelerator. It generalises the controller's fixed 3-way memory control to NUM_CH channels.
//  - Round-robin arbitration of channel requests onto one memory port.
//  - Per-channel auto-incrementing address generators.
//  - Per-channel read or write direction.
//  - Grant-order tag FIFO that routes in-order read responses back to the issuing channel.
//  - Flush that discards responses still in flight.
// PARAMETERS
//  NUM_CH        4    number of requesting channels (2..8)
//  ADDR_W        32   memory address width
//  DATA_W        256  memory data width (MEM_BANDWIDTH*8)
//  MAX_OUTST     16   max outstanding reads; tag FIFO depth (power of 2)
//  CH_WR_MASK    4'b1000  bit i=1: channel i is a write channel
// PORTS
//  clk             in   1                clock
//  rst_n           in   1                async active-low reset
//  flush           in   1                sync restart (layer start)
//  ch_start_addr   in   NUM_CH*ADDR_W    per-channel base address, sampled on flush
//  ch_req          in   NUM_CH           channel request (level)
//  ch_ack          out  NUM_CH           one-hot grant, same cycle as issue
//  ch_wdata        in   NUM_CH*DATA_W    write data, valid with ch_req (write channels)
//  ch_rdata        out  DATA_W           broadcast read data
//  ch_rvalid       out  NUM_CH           one-hot read-data valid
//  mem_addr        out  ADDR_W           memory address
//  mem_ren         out  1                read issue
//  mem_wen         out  1                write issue
//  mem_wdata       out  DATA_W           write data
//  mem_rdata       in   DATA_W           read data
//  mem_rvalid      in   1                read data valid (in order, latency >=1)
//  outstanding     out  $clog2(MAX_OUTST+1)  reads in flight
//  err_orphan      out  1                sticky: mem_rvalid with no tag and no drain pending
// BEHAVIOUR
//  Reset values:
//  - All outputs 0; address counters 0; RR pointer = channel 0; FIFO empty; drain_cnt 0.
//  Eligibility:
//  - Read channel i is eligible iff ch_req[i] & tag FIFO not full (pushes count, pops do not free a slot same cycle).
//  - Write channel i is eligible iff ch_req[i]; writes never use the FIFO.
//  - flush=1 forces no channel eligible that cycle.
//  Arbitration (combinational):
//  - Grant the first eligible channel at or after the RR pointer, wrapping.
//  - ch_ack = grant; at most one hot.
//  - mem_addr = addr[g]; mem_ren = grant to a read channel; mem_wen = grant to a write channel; mem_wdata = ch_wdata[g].
//  - All issue outputs are 0 with no grant.
//  Registered updates on grant of g:
//  - addr[g] += 1, wrapping modulo 2^ADDR_W.
//  - RR pointer <= (g+1) mod NUM_CH; the pointer holds with no grant.
//  Tag FIFO:
//  - Push g on each read grant. Pop on each mem_rvalid while drain_cnt==0.
//  - ch_rvalid[head]=mem_rvalid and ch_rdata=mem_rdata in the same cycle, with no added latency.
//  - Simultaneous push and pop in one cycle is legal, and occupancy is unchanged.
//  - outstanding = FIFO occupancy.
//  Flush (one cycle):
//  - addr[i] <= ch_start_addr[i]; RR pointer <= 0; FIFO cleared.
//  - drain_cnt <= occupancy; if mem_rvalid arrives in the flush cycle, drain_cnt <= occupancy-1.
//  - While drain_cnt>0, each mem_rvalid is dropped (no ch_rvalid) and decrements drain_cnt.
//  - New reads may issue during drain. Their responses arrive after all drained ones, so the FIFO stays consistent.
//  Orphan response:
//  - mem_rvalid with FIFO empty and drain_cnt==0 is dropped and sets err_orphan.
//  - err_orphan is cleared only by rst_n or flush.
//  Reset mid-operation:
//  - Everything returns to reset values immediately; in-flight responses after reset count as orphans.
// STRUCTURE
//  Package (amadeus_pkg):
//  - typedef logic [$clog2(NUM_CH)-1:0] ch_id_t.
//  - localparam MEM_DATA_W = MEM_BANDWIDTH*8.
//  - Channel index constants CH_IFMAP=0, CH_WEIGHT=1, CH_PSUM=2, CH_COMPRESSOR=3.
//  Sub-module:
//  - rr_arbiter #(NUM_CH) holds the combinational pick and pointer register.
//  - The tag FIFO is an instance of the existing fifo with DTYPE=ch_id_t and DEPTH=MAX_OUTST.
//  DV assertions:
//  - ch_ack and ch_rvalid are onehot0.
//  - No push when full.
//  - mem_ren & mem_wen is never 1.
// TESTING
//  1. ch_start_addr={0x300,0x200,0x100,0x000}, flush, ch_req=4'b0111 held 6 cycles
//     -> grants 0,1,2,0,1,2; addrs 0x000,0x100,0x200,0x001,0x101,0x201.
//  2. Read latency 3 on grants 0,2,1 -> ch_rvalid sequence 0001,0100,0010 with matching mem_rdata; outstanding back to 0.
//  3. Hold ch_req[0] with memory stalled -> exactly 16 grants, then ch_ack=0 and outstanding=16.
//     Release one mem_rvalid -> grant resumes the next cycle.
//  4. 5 reads outstanding, flush, 2 new reads issued -> first 5 mem_rvalid dropped; next 2 routed correctly; err_orphan=0.
//  5. mem_rvalid with nothing outstanding -> no ch_rvalid; err_orphan=1 until flush.
//  6. Write channel 3 plus read channel 0 requesting together
//     -> alternating mem_wen/mem_ren; mem_wdata=ch_wdata[3] on write cycles; addr[3] at 0xFFFFFFFF wraps to 0.

Source files
------------

// File: rtl/amadeus_pkg.sv
// Shared constants and types for the accelerator memory subsystem.
package amadeus_pkg;
    localparam int MEM_BANDWIDTH = 32;
    localparam int MEM_DATA_W    = MEM_BANDWIDTH * 8;
    localparam int DEF_NUM_CH    = 4;

    localparam int CH_IFMAP      = 0;
    localparam int CH_WEIGHT     = 1;
    localparam int CH_PSUM       = 2;
    localparam int CH_COMPRESSOR = 3;

    typedef logic [$clog2(DEF_NUM_CH)-1:0] ch_id_t;
endpackage

// File: rtl/mem_channel_arbiter_fifo.sv
// Synchronous FIFO with occupancy count and single-cycle clear.
module fifo #(
    parameter type DTYPE  = logic,
    parameter int  DEPTH  = 16,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  DTYPE             din,
    input  logic             pop,
    output DTYPE             dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    DTYPE             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/mem_channel_arbiter_rr_arbiter.sv
// Round-robin pick among eligible channels; pointer advances past each winner.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    localparam int CH_W  = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [NUM_CH-1:0] eligible,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx,
    output logic              grant_valid
);
    logic [CH_W-1:0] ptr;
    logic [CH_W-1:0] cand;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = CH_W'((int'(ptr) + k) % NUM_CH);
            if (!grant_valid && eligible[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
        grant            = '0;
        grant[grant_idx] = grant_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (grant_valid) begin
            ptr <= (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + 1'b1;
        end
    end
endmodule

// File: rtl/mem_channel_arbiter.sv
// Shared memory port: round-robin channel arbitration, per-channel address
// generators, and in-order read-response routing through a grant-order tag FIFO.
module mem_channel_arbiter
    import amadeus_pkg::*;
#(
    parameter int                NUM_CH     = DEF_NUM_CH,
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = MEM_DATA_W,
    parameter int                MAX_OUTST  = 16,
    parameter logic [NUM_CH-1:0] CH_WR_MASK = NUM_CH'(4'b1000),
    localparam int               CH_W       = $clog2(NUM_CH),
    localparam int               OCC_W      = $clog2(MAX_OUTST + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [NUM_CH*ADDR_W-1:0] ch_start_addr,
    input  logic [NUM_CH-1:0]        ch_req,
    output logic [NUM_CH-1:0]        ch_ack,
    input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
    output logic [DATA_W-1:0]        ch_rdata,
    output logic [NUM_CH-1:0]        ch_rvalid,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     mem_ren,
    output logic                     mem_wen,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_rvalid,
    output logic [OCC_W-1:0]         outstanding,
    output logic                     err_orphan
);
    typedef logic [CH_W-1:0] tag_t;

    logic [ADDR_W-1:0] addr [NUM_CH];
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] grant;
    tag_t              grant_idx;
    tag_t              head;
    logic              grant_valid;
    logic              is_write;
    logic              fifo_full;
    logic              fifo_empty;
    logic              draining;
    logic              route;
    logic [OCC_W-1:0]  occupancy;
    logic [OCC_W-1:0]  drain_cnt;

    // A full tag FIFO only blocks reads; writes never need a response slot.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            eligible[i] = !flush && ch_req[i] && (CH_WR_MASK[i] || !fifo_full);
        end
    end

    rr_arbiter #(.NUM_CH(NUM_CH)) u_rr_arbiter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (flush),
        .eligible   (eligible),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid)
    );

    assign is_write  = CH_WR_MASK[grant_idx];
    assign ch_ack    = grant;
    assign mem_ren   = grant_valid && !is_write;
    assign mem_wen   = grant_valid && is_write;
    assign mem_addr  = grant_valid ? addr[grant_idx] : '0;
    assign mem_wdata = grant_valid ? ch_wdata[grant_idx*DATA_W +: DATA_W] : '0;

    // Responses belonging to a flushed batch are swallowed before routing resumes.
    assign draining = (drain_cnt != '0);
    assign route    = mem_rvalid && !flush && !draining && !fifo_empty;
    assign ch_rdata = mem_rdata;

    always_comb begin
        ch_rvalid       = '0;
        ch_rvalid[head] = route;
    end

    fifo #(.DTYPE(tag_t), .DEPTH(MAX_OUTST)) u_tag_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(flush),
        .push (mem_ren),
        .din  (grant_idx),
        .pop  (route),
        .dout (head),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(occupancy)
    );

    assign outstanding = occupancy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) addr[i] <= '0;
            drain_cnt  <= '0;
            err_orphan <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < NUM_CH; i++) addr[i] <= ch_start_addr[i*ADDR_W +: ADDR_W];
            drain_cnt  <= (mem_rvalid && occupancy != '0) ? occupancy - 1'b1 : occupancy;
            err_orphan <= 1'b0;
        end else begin
            if (grant_valid) addr[grant_idx] <= addr[grant_idx] + 1'b1;
            if (mem_rvalid && draining) drain_cnt <= drain_cnt - 1'b1;
            if (mem_rvalid && !draining && fifo_empty) err_orphan <= 1'b1;
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ch_ack));
    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ch_rvalid));
    assert property (@(posedge clk) disable iff (!rst_n) !(mem_ren && fifo_full));
    assert property (@(posedge clk) disable iff (!rst_n) !(mem_ren && mem_wen));
endmodule
